// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// Module : wb_port_arbiter_if
// Brief  : Writeback request/grant bus and register-file write port bundle.
//          Forwarding signals exist only when WB_ARB_FWD_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              reg_write_en;
   logic [ADDR_W-1:0] reg_wr_addr;
   logic [DATA_W-1:0] reg_wr_data;
   logic              addr_err;
`ifdef WB_ARB_FWD_EN
   logic [ADDR_W-1:0] fwd_rd_addr_1;
   logic [ADDR_W-1:0] fwd_rd_addr_2;
   logic              fwd_hit_1;
   logic              fwd_hit_2;
   logic [DATA_W-1:0] fwd_data_1;
   logic [DATA_W-1:0] fwd_data_2;
`endif

   modport slave (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
      output alu_ready, mem_ready, reg_write_en, reg_wr_addr, reg_wr_data, addr_err
`ifdef WB_ARB_FWD_EN
      , input  fwd_rd_addr_1, fwd_rd_addr_2
      , output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
`endif
   );

   modport master (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
      input  alu_ready, mem_ready, reg_write_en, reg_wr_addr, reg_wr_data, addr_err
`ifdef WB_ARB_FWD_EN
      , output fwd_rd_addr_1, fwd_rd_addr_2
      , input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
`endif
   );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module : wb_port_arbiter
// Brief  : Shares one register-file write port between ALU and load writeback
//          with ALU anti-starvation. Optional forwarding: WB_ARB_FWD_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 8,
   parameter int STARVE_MAX = 3
) (
   input  wire logic            clk,
   input  wire logic            rst,
   wb_port_arbiter_if.slave     wb
);

   typedef enum logic [0:0] {
      MEM_PRI   = 1'b0,
      ALU_FORCE = 1'b1
   } state_t;

   localparam logic [3:0]      c_STARVE_MAX = 4'(STARVE_MAX);
   localparam logic [ADDR_W:0] c_NUM_REGS   = (ADDR_W+1)'(NUM_REGS);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              w_alu_gnt, w_mem_gnt;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic [DATA_W-1:0] w_gnt_data;
   logic              w_gnt_oor;
   logic              w_wr_en_d;
   logic              w_err_d;

   logic              reg_write_en_q;
   logic [ADDR_W-1:0] reg_wr_addr_q;
   logic [DATA_W-1:0] reg_wr_data_q;
   logic              addr_err_q;

   always_comb begin
      w_alu_gnt = 1'b0;
      w_mem_gnt = 1'b0;
      state_d   = state_q;
      cnt_d     = cnt_q;

      case (state_q)
         MEM_PRI: begin
            w_mem_gnt = wb.mem_valid;
            w_alu_gnt = wb.alu_valid && !wb.mem_valid;
         end
         ALU_FORCE: begin
            w_alu_gnt = wb.alu_valid;
            w_mem_gnt = wb.mem_valid && !wb.alu_valid;
         end
         default: ;
      endcase

      // Counter tracks consecutive cycles the ALU was waiting and lost.
      if (!wb.alu_valid || w_alu_gnt)
         cnt_d = 4'd0;
      else if (cnt_q < c_STARVE_MAX)
         cnt_d = cnt_q + 4'd1;

      case (state_q)
         MEM_PRI: begin
            if (cnt_d == c_STARVE_MAX)
               state_d = ALU_FORCE;
         end
         ALU_FORCE: begin
            if (w_alu_gnt || !wb.alu_valid) begin
               state_d = MEM_PRI;
               cnt_d   = 4'd0;
            end
         end
         default: state_d = MEM_PRI;
      endcase
   end

   always_comb begin
      w_gnt_addr = w_alu_gnt ? wb.alu_addr : wb.mem_addr;
      w_gnt_data = w_alu_gnt ? wb.alu_data : wb.mem_data;
      w_gnt_oor  = {1'b0, w_gnt_addr} >= c_NUM_REGS;
      w_wr_en_d  = (w_alu_gnt || w_mem_gnt) && (w_gnt_addr != '0) && !w_gnt_oor;
      w_err_d    = (w_alu_gnt || w_mem_gnt) && w_gnt_oor;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= MEM_PRI;
         cnt_q          <= 4'd0;
         reg_write_en_q <= 1'b0;
         reg_wr_addr_q  <= '0;
         reg_wr_data_q  <= '0;
         addr_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         reg_write_en_q <= w_wr_en_d;
         addr_err_q     <= w_err_d;
         if (w_wr_en_d) begin
            reg_wr_addr_q <= w_gnt_addr;
            reg_wr_data_q <= w_gnt_data;
         end
      end
   end

   assign wb.alu_ready    = w_alu_gnt;
   assign wb.mem_ready    = w_mem_gnt;
   assign wb.reg_write_en = reg_write_en_q;
   assign wb.reg_wr_addr  = reg_wr_addr_q;
   assign wb.reg_wr_data  = reg_wr_data_q;
   assign wb.addr_err     = addr_err_q;

`ifdef WB_ARB_FWD_EN
   // Lets read ports see the value landing in the register file this edge.
   assign wb.fwd_hit_1  = reg_write_en_q && (reg_wr_addr_q == wb.fwd_rd_addr_1);
   assign wb.fwd_hit_2  = reg_write_en_q && (reg_wr_addr_q == wb.fwd_rd_addr_2);
   assign wb.fwd_data_1 = wb.fwd_hit_1 ? reg_wr_data_q : '0;
   assign wb.fwd_data_2 = wb.fwd_hit_2 ? reg_wr_data_q : '0;
`endif

endmodule

`default_nettype wire
